// File: rtl/data_memory_pkg.sv
// Shared definitions for the sized data memory: access-size codes,
// controller states and the default byte address of word 0.
package data_memory_pkg;

    localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: store-lane merge, load extraction/extension,
// and size/alignment fault detection for little-endian 32-bit words.
module mem_lane_align
    import data_memory_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] merged_word_o,
    output logic [31:0] load_data_o,
    output logic        align_fault_o
);

    logic [7:0]  load_byte_s;
    logic [15:0] load_half_s;

    // Select the addressed byte and halfword from the stored word.
    always_comb begin
        load_byte_s = 8'h00;
        case (lane_i)
            2'd0:    load_byte_s = old_word_i[7:0];
            2'd1:    load_byte_s = old_word_i[15:8];
            2'd2:    load_byte_s = old_word_i[23:16];
            2'd3:    load_byte_s = old_word_i[31:24];
            default: load_byte_s = 8'h00;
        endcase
        if (lane_i[1]) begin
            load_half_s = old_word_i[31:16];
        end else begin
            load_half_s = old_word_i[15:0];
        end
    end

    // Merge store lanes, right-justify loads, flag illegal size or misalignment.
    always_comb begin
        merged_word_o = old_word_i;
        load_data_o   = 32'h0000_0000;
        align_fault_o = 1'b0;
        case (size_i)
            SIZE_BYTE: begin
                if (sign_i) begin
                    load_data_o = {{24{load_byte_s[7]}}, load_byte_s};
                end else begin
                    load_data_o = {24'h00_0000, load_byte_s};
                end
                case (lane_i)
                    2'd0:    merged_word_o[7:0]   = store_data_i[7:0];
                    2'd1:    merged_word_o[15:8]  = store_data_i[7:0];
                    2'd2:    merged_word_o[23:16] = store_data_i[7:0];
                    2'd3:    merged_word_o[31:24] = store_data_i[7:0];
                    default: merged_word_o        = old_word_i;
                endcase
            end
            SIZE_HALF: begin
                align_fault_o = lane_i[0];
                if (sign_i) begin
                    load_data_o = {{16{load_half_s[15]}}, load_half_s};
                end else begin
                    load_data_o = {16'h0000, load_half_s};
                end
                if (lane_i[1]) begin
                    merged_word_o[31:16] = store_data_i[15:0];
                end else begin
                    merged_word_o[15:0] = store_data_i[15:0];
                end
            end
            SIZE_WORD: begin
                align_fault_o = (lane_i != 2'b00);
                load_data_o   = old_word_i;
                merged_word_o = store_data_i;
            end
            default: begin
                align_fault_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_sized.sv
// Multi-cycle data memory with byte/half/word access, fixed wait states
// and fault reporting; IDLE -> WAIT -> DONE handshake toward a stalling pipeline.
module data_memory_sized
    import data_memory_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic [31:0] ALUresult,
    input  logic [31:0] WriteData,
    output logic [31:0] data_result,
    output logic        mem_busy,
    output logic        mem_done,
    output logic        mem_fault
);

    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic        NO_WAIT    = (WAIT_STATES == 0);
    localparam logic [3:0]  WAIT_LOAD  = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    mem_state_e  state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [1:0]  req_size_q, req_size_d;
    logic        req_sign_q, req_sign_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic        req_rd_q, req_rd_d;
    logic        req_wr_q, req_wr_d;
    logic [31:0] data_result_q, data_result_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;

    logic             idle_s;
    logic             accept_s;
    logic [31:0]      cur_addr_s;
    logic [1:0]       cur_size_s;
    logic             cur_sign_s;
    logic [31:0]      cur_wdata_s;
    logic             cur_rd_s;
    logic             cur_wr_s;
    logic [31:0]      offset_s;
    logic             in_range_s;
    logic [IDX_W-1:0] word_idx_s;
    logic [31:0]      rd_word_s;
    logic [31:0]      merged_word_s;
    logic [31:0]      load_data_s;
    logic             align_fault_s;
    logic             fault_s;
    logic             enter_done_s;
    logic             mem_we_s;

    // Contents start at zero and are deliberately outside the reset domain.
    logic [31:0] mem_q [DEPTH_WORDS] = '{default: 32'h0000_0000};

    // In IDLE the request is taken straight from the ports so a zero-wait access can finish on its accepting edge.
    always_comb begin
        idle_s   = (state_q == ST_IDLE);
        accept_s = idle_s && (MemRead || MemWrite);
        if (idle_s) begin
            cur_addr_s  = ALUresult;
            cur_size_s  = MemSize;
            cur_sign_s  = MemSigned;
            cur_wdata_s = WriteData;
            cur_rd_s    = MemRead;
            cur_wr_s    = MemWrite;
        end else begin
            cur_addr_s  = req_addr_q;
            cur_size_s  = req_size_q;
            cur_sign_s  = req_sign_q;
            cur_wdata_s = req_wdata_q;
            cur_rd_s    = req_rd_q;
            cur_wr_s    = req_wr_q;
        end
        offset_s   = cur_addr_s - BASE_ADDR;
        in_range_s = (offset_s < SPAN_BYTES);
        word_idx_s = offset_s[IDX_W+1:2];
        rd_word_s  = mem_q[word_idx_s];
    end

    mem_lane_align u_lane_align (
        .size_i        (cur_size_s),
        .sign_i        (cur_sign_s),
        .lane_i        (cur_addr_s[1:0]),
        .old_word_i    (rd_word_s),
        .store_data_i  (cur_wdata_s),
        .merged_word_o (merged_word_s),
        .load_data_o   (load_data_s),
        .align_fault_o (align_fault_s)
    );

    // Next-state, wait down-counter and request latch.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        req_addr_d  = req_addr_q;
        req_size_d  = req_size_q;
        req_sign_d  = req_sign_q;
        req_wdata_d = req_wdata_q;
        req_rd_d    = req_rd_q;
        req_wr_d    = req_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    req_addr_d  = ALUresult;
                    req_size_d  = MemSize;
                    req_sign_d  = MemSigned;
                    req_wdata_d = WriteData;
                    req_rd_d    = MemRead;
                    req_wr_d    = MemWrite;
                    if (NO_WAIT) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = 4'd0;
            end
        endcase
    end

    // Completion: fault decode, array write enable and registered outputs.
    always_comb begin
        fault_s      = !in_range_s || align_fault_s || (cur_rd_s && cur_wr_s);
        enter_done_s = (state_d == ST_DONE);
        // Gated by reset so an edge seen while reset is low can never commit.
        mem_we_s     = enter_done_s && cur_wr_s && !fault_s && reset;
        busy_d       = (state_d != ST_IDLE);
        done_d       = enter_done_s;
        fault_d      = enter_done_s && fault_s;
        data_result_d = data_result_q;
        if (enter_done_s) begin
            if (fault_s) begin
                data_result_d = 32'h0000_0000;
            end else if (cur_rd_s) begin
                data_result_d = load_data_s;
            end else begin
                data_result_d = data_result_q;
            end
        end else begin
            data_result_d = data_result_q;
        end
    end

    // Controller and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= 4'd0;
            req_addr_q    <= 32'h0000_0000;
            req_size_q    <= 2'b00;
            req_sign_q    <= 1'b0;
            req_wdata_q   <= 32'h0000_0000;
            req_rd_q      <= 1'b0;
            req_wr_q      <= 1'b0;
            data_result_q <= 32'h0000_0000;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            req_addr_q    <= req_addr_d;
            req_size_q    <= req_size_d;
            req_sign_q    <= req_sign_d;
            req_wdata_q   <= req_wdata_d;
            req_rd_q      <= req_rd_d;
            req_wr_q      <= req_wr_d;
            data_result_q <= data_result_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
        end
    end

    // Word array write port.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[word_idx_s] <= merged_word_s;
        end
    end

    assign data_result = data_result_q;
    assign mem_busy    = busy_q;
    assign mem_done    = done_q;
    assign mem_fault   = fault_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench: a 2-wait-state instance for functional/fault/reset cases
// and a 0-wait-state instance for back-to-back streaming.
module tb_data_memory_sized;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef struct {
        logic [31:0] data;
        logic        fault;
        logic        chk;
        int          acc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    int   b_done_cnt;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    logic        a_rd, a_wr, a_sg, b_rd, b_wr, b_sg;
    logic [1:0]  a_sz, b_sz;
    logic [31:0] a_addr, a_wd, b_addr, b_wd;
    logic [31:0] a_data, b_data;
    logic        a_busy, a_done, a_fault, b_busy, b_done, b_fault;

    data_memory_sized #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h1001_0000), .WAIT_STATES(2)) u_dut_ws2 (
        .clk(clk), .reset(reset), .MemRead(a_rd), .MemWrite(a_wr), .MemSize(a_sz),
        .MemSigned(a_sg), .ALUresult(a_addr), .WriteData(a_wd), .data_result(a_data),
        .mem_busy(a_busy), .mem_done(a_done), .mem_fault(a_fault)
    );

    data_memory_sized #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h1001_0000), .WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .reset(reset), .MemRead(b_rd), .MemWrite(b_wr), .MemSize(b_sz),
        .MemSigned(b_sg), .ALUresult(b_addr), .WriteData(b_wd), .data_result(b_data),
        .mem_busy(b_busy), .mem_done(b_done), .mem_fault(b_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // mem_done is expected to be visible in the (WAIT_STATES+1)th cycle after the
    // accepting edge, i.e. WAIT_STATES edges after it.
    always @(negedge clk) begin
        if (a_done === 1'b1) begin
            checks++;
            assert (qa.size() != 0) else begin
                errors++; $error("FAIL a_unexpected_done got done=1 required no pending request");
            end
            if (qa.size() != 0) begin
                ea = qa.pop_front();
                checks++;
                assert ((cyc - ea.acc) === 2) else begin
                    errors++; $error("FAIL a_latency got %0d required 2", cyc - ea.acc);
                end
                checks++;
                assert (a_fault === ea.fault) else begin
                    errors++; $error("FAIL a_fault got %b required %b", a_fault, ea.fault);
                end
                if (ea.chk) begin
                    checks++;
                    assert (a_data === ea.data) else begin
                        errors++; $error("FAIL a_data got %h required %h", a_data, ea.data);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (b_done === 1'b1) begin
            b_done_cnt++;
            checks++;
            assert (qb.size() != 0) else begin
                errors++; $error("FAIL b_unexpected_done got done=1 required no pending request");
            end
            if (qb.size() != 0) begin
                eb = qb.pop_front();
                checks++;
                assert ((cyc - eb.acc) === 0) else begin
                    errors++; $error("FAIL b_latency got %0d required 0", cyc - eb.acc);
                end
                checks++;
                assert (b_fault === eb.fault) else begin
                    errors++; $error("FAIL b_fault got %b required %b", b_fault, eb.fault);
                end
                if (eb.chk) begin
                    checks++;
                    assert (b_data === eb.data) else begin
                        errors++; $error("FAIL b_data got %h required %h", b_data, eb.data);
                    end
                end
            end
        end
    end

    task automatic wait_done_a();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (a_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        assert (seen) else begin
            errors++; $error("FAIL a_timeout got no mem_done required mem_done within 16 cycles");
        end
    endtask

    task automatic req_a(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_f, input logic chk);
        exp_t e;
        @(negedge clk);
        a_rd = rd; a_wr = wr; a_sz = sz; a_sg = sg; a_addr = addr; a_wd = wd;
        e.data = exp_d; e.fault = exp_f; e.chk = chk; e.acc = cyc + 1;
        qa.push_back(e);
        @(negedge clk);
        a_rd = 1'b0; a_wr = 1'b0;
        wait_done_a();
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        assert (a_data === 32'h0 && b_data === 32'h0) else begin
            errors++; $error("FAIL %s_data got %h/%h required 0/0", tag, a_data, b_data);
        end
        checks++;
        assert ({a_busy, a_done, a_fault, b_busy, b_done, b_fault} === 6'b000000) else begin
            errors++; $error("FAIL %s_flags got %b required 000000", tag,
                             {a_busy, a_done, a_fault, b_busy, b_done, b_fault});
        end
    endtask

    initial begin
        logic [31:0] stream_d [4];
        exp_t e;
        checks = 0; errors = 0; b_done_cnt = 0;
        a_rd = 1'b0; a_wr = 1'b0; a_sz = SZ_W; a_sg = 1'b0; a_addr = 32'h0; a_wd = 32'h0;
        b_rd = 1'b0; b_wr = 1'b0; b_sz = SZ_W; b_sg = 1'b0; b_addr = 32'h0; b_wd = 32'h0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b1;

        // word store/load
        req_a(1'b0, 1'b1, SZ_W, 1'b0, 32'h1001_0000, 32'h1122_3344, 32'h0, 1'b0, 1'b0);
        req_a(1'b1, 1'b0, SZ_W, 1'b0, 32'h1001_0000, 32'h0, 32'h1122_3344, 1'b0, 1'b1);
        // byte store, upper WriteData bits must be ignored
        req_a(1'b0, 1'b1, SZ_B, 1'b0, 32'h1001_0005, 32'h1234_56AB, 32'h0, 1'b0, 1'b0);
        req_a(1'b1, 1'b0, SZ_B, 1'b0, 32'h1001_0005, 32'h0, 32'h0000_00AB, 1'b0, 1'b1);
        req_a(1'b1, 1'b0, SZ_B, 1'b1, 32'h1001_0005, 32'h0, 32'hFFFF_FFAB, 1'b0, 1'b1);
        req_a(1'b1, 1'b0, SZ_W, 1'b0, 32'h1001_0004, 32'h0, 32'h0000_AB00, 1'b0, 1'b1);
        // halfword in upper lanes
        req_a(1'b0, 1'b1, SZ_H, 1'b0, 32'h1001_0012, 32'h5A5A_8001, 32'h0, 1'b0, 1'b0);
        req_a(1'b1, 1'b0, SZ_H, 1'b1, 32'h1001_0012, 32'h0, 32'hFFFF_8001, 1'b0, 1'b1);
        req_a(1'b1, 1'b0, SZ_H, 1'b0, 32'h1001_0012, 32'h0, 32'h0000_8001, 1'b0, 1'b1);
        req_a(1'b1, 1'b0, SZ_W, 1'b0, 32'h1001_0010, 32'h0, 32'h8001_0000, 1'b0, 1'b1);
        // other lanes of word 0
        req_a(1'b1, 1'b0, SZ_H, 1'b1, 32'h1001_0000, 32'h0, 32'h0000_3344, 1'b0, 1'b1);
        req_a(1'b1, 1'b0, SZ_B, 1'b1, 32'h1001_0003, 32'h0, 32'h0000_0011, 1'b0, 1'b1);
        // faults: misaligned, below base, past end, illegal size, read+write
        req_a(1'b1, 1'b0, SZ_W, 1'b0, 32'h1001_0002, 32'h0, 32'h0, 1'b1, 1'b1);
        req_a(1'b0, 1'b1, SZ_H, 1'b0, 32'h1001_0003, 32'h0000_FFFF, 32'h0, 1'b1, 1'b1);
        req_a(1'b1, 1'b0, SZ_W, 1'b0, 32'h0FFF_FFFC, 32'h0, 32'h0, 1'b1, 1'b1);
        req_a(1'b1, 1'b0, SZ_W, 1'b0, 32'h1001_1000, 32'h0, 32'h0, 1'b1, 1'b1);
        req_a(1'b1, 1'b0, SZ_X, 1'b0, 32'h1001_0000, 32'h0, 32'h0, 1'b1, 1'b1);
        req_a(1'b1, 1'b1, SZ_W, 1'b0, 32'h1001_0010, 32'h0, 32'h0, 1'b1, 1'b1);
        // faulting stores left the array alone
        req_a(1'b1, 1'b0, SZ_W, 1'b0, 32'h1001_0000, 32'h0, 32'h1122_3344, 1'b0, 1'b1);
        req_a(1'b1, 1'b0, SZ_W, 1'b0, 32'h1001_0010, 32'h0, 32'h8001_0000, 1'b0, 1'b1);
        // last word of the array
        req_a(1'b0, 1'b1, SZ_W, 1'b0, 32'h1001_0FFC, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0);
        req_a(1'b1, 1'b0, SZ_W, 1'b0, 32'h1001_0FFC, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);

        // store aborted by reset in WAIT
        @(negedge clk);
        a_wr = 1'b1; a_sz = SZ_W; a_addr = 32'h1001_0008; a_wd = 32'hDEAD_BEEF;
        @(negedge clk);
        a_wr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_idle_outputs("abort");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        req_a(1'b1, 1'b0, SZ_W, 1'b0, 32'h1001_0008, 32'h0, 32'h0000_0000, 1'b0, 1'b1);

        // zero-wait stream: requests held high, type alternating every accept
        stream_d[0] = 32'h0BAD_F00D; stream_d[1] = 32'h1234_5678;
        stream_d[2] = 32'hFFFF_FFFF; stream_d[3] = 32'h00C0_FFEE;
        b_sz = SZ_W; b_sg = 1'b0; b_addr = 32'h1001_000C;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            b_wr = (i % 2 == 0);
            b_rd = (i % 2 == 1);
            b_wd = stream_d[i / 2];
            e.data = stream_d[i / 2]; e.fault = 1'b0; e.chk = (i % 2 == 1); e.acc = cyc + 1;
            qb.push_back(e);
            @(negedge clk);
        end
        b_rd = 1'b0; b_wr = 1'b0;

        repeat (4) @(negedge clk);
        checks++;
        assert (b_done_cnt === 8) else begin
            errors++; $error("FAIL b_done_count got %0d required 8", b_done_cnt);
        end
        checks++;
        assert (qa.size() === 0 && qb.size() === 0) else begin
            errors++; $error("FAIL pending_left got %0d/%0d required 0/0", qa.size(), qb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion required finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
